// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the UART transmit port; define UART_ARB_PACKET_LOCK_EN for packet lock with idle timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   pick_d;
  logic               xfer;

`ifdef UART_ARB_PACKET_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0]   idle_q;
  logic               timeout_q;
  assign timeout = timeout_q;
`else
  localparam int unused_lock_timeout = LOCK_TIMEOUT;
  logic unused_last;
  assign unused_last = ^req_last;
  assign timeout     = 1'b0;
`endif

  // Round-robin search: first requester above the last owner, wrapping around
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    cand   = '0;
    pick_d = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        pick_d = cand;
      end
    end
  end

  // Owner's byte stream is steered straight to the driver while a grant is held
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    if (state_q == S_SEND) begin
      tx_data           = req_data[gidx_q*DATA_BITS +: DATA_BITS];
      tx_valid          = req_valid[gidx_q];
      req_ready[gidx_q] = tx_ready;
    end
  end

  assign xfer  = (state_q == S_SEND) && req_valid[gidx_q] && tx_ready;
  assign grant = grant_q;
  assign busy  = (state_q == S_SEND);

  // Grant FSM: arbitrate in idle, hold the owner until release or forced timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      gidx_q    <= '0;
`ifdef UART_ARB_PACKET_LOCK_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_PACKET_LOCK_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q <= NUM_REQ'(1) << pick_d;
            gidx_q  <= pick_d;
            state_q <= S_SEND;
`ifdef UART_ARB_PACKET_LOCK_EN
            idle_q  <= '0;
`endif
          end
        end
        S_SEND: begin
`ifdef UART_ARB_PACKET_LOCK_EN
          // A last byte on the timeout edge counts as a normal release
          if (xfer) begin
            if (req_last[gidx_q]) begin
              ptr_q   <= gidx_q;
              grant_q <= '0;
              state_q <= S_IDLE;
            end else begin
              idle_q  <= '0;
            end
          end else if (idle_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            ptr_q     <= gidx_q;
            grant_q   <= '0;
            state_q   <= S_IDLE;
            timeout_q <= 1'b1;
          end else begin
            idle_q    <= idle_q + 1'b1;
          end
`else
          // Per-byte round robin: release after one cycle, transfer or not
          ptr_q   <= gidx_q;
          grant_q <= '0;
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LT = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_valid, req_last, req_ready, grant;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ready, busy, timeout;

  typedef struct { int idx; logic [W-1:0] data; } exp_t;
  exp_t sb[$];

  logic [W:0]   src_mem [N][32];
  int           src_hd  [N] = '{default: 0};
  int           src_tl  [N] = '{default: 0};
  logic [N-1:0] src_en;
  logic [N-1:0] xfer_s = '0;

  int total = 0;
  int bad   = 0;
  bit to_seen = 1'b0;
  int cnt;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(W), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Requester models present the head of their byte queue
  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (src_en[i] && src_hd[i] != src_tl[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = src_mem[i][src_hd[i] % 32][W];
        req_data[i*W +: W] = src_mem[i][src_hd[i] % 32][W-1:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte offered to the driver must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    xfer_s = req_ready & req_valid;
    if (timeout === 1'b1) to_seen = 1'b1;
    if (rst_n && tx_valid && tx_ready) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("xfer_grant", 32'(grant), 32'(1) << e.idx);
        chk("xfer_data", 32'(tx_data), 32'(e.data));
        chk("xfer_ready", 32'(req_ready), 32'(1) << e.idx);
      end
    end
  end

  // Accepted bytes leave their requester queue; reset flushes the queues
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) src_hd[i] = src_tl[i];
      else if (xfer_s[i]) src_hd[i] = src_hd[i] + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic last, input logic [W-1:0] d);
    src_mem[i][src_tl[i] % 32] = {last, d};
    src_tl[i] = src_tl[i] + 1;
  endtask

  task automatic exp_push(input int i, input logic [W-1:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) step();
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_outputs", 32'({grant, busy, timeout, tx_valid, req_ready, tx_data}), 0);
    chk("rst_sb_empty", sb.size(), 0);
    sb.delete();
    src_en   = '1;
    tx_ready = 1'b1;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    src_en   = '1;

    // Single requester, two bytes
    do_reset();
    push(2, 1'b0, 8'h41); push(2, 1'b1, 8'h42);
    exp_push(2, 8'h41);   exp_push(2, 8'h42);
    step();
    chk("t1_grant", 32'(grant), 32'b0100);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_req_ready", 32'(req_ready), 32'b0100);
    chk("t1_tx_valid", 32'(tx_valid), 1);
    drain(20);
    step();
    chk("t1_release", 32'({grant, busy}), 0);

    // Four simultaneous 2-byte packets
    do_reset();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++) push(i, b == 1, 8'(8'h10 + i*2 + b));
`ifdef UART_ARB_PACKET_LOCK_EN
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++) exp_push(i, 8'(8'h10 + i*2 + b));
`else
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) exp_push(i, 8'(8'h10 + i*2 + b));
`endif
    step();
    chk("t2_first_grant", 32'(grant), 32'b0001);
    drain(60);
    step();
    chk("t2_release", 32'({grant, busy}), 0);

    // Fairness: requester 0 re-requests, requester 3 pending
    do_reset();
    push(0, 1'b0, 8'hA0); push(0, 1'b1, 8'hA1);
    push(0, 1'b0, 8'hB0); push(0, 1'b1, 8'hB1);
    push(3, 1'b0, 8'hC0); push(3, 1'b1, 8'hC1);
`ifdef UART_ARB_PACKET_LOCK_EN
    exp_push(0, 8'hA0); exp_push(0, 8'hA1);
    exp_push(3, 8'hC0); exp_push(3, 8'hC1);
    exp_push(0, 8'hB0); exp_push(0, 8'hB1);
`else
    exp_push(0, 8'hA0); exp_push(3, 8'hC0);
    exp_push(0, 8'hA1); exp_push(3, 8'hC1);
    exp_push(0, 8'hB0); exp_push(0, 8'hB1);
`endif
    step();
    chk("t3_first_grant", 32'(grant), 32'b0001);
    drain(40);

`ifdef UART_ARB_PACKET_LOCK_EN
    // Stalled packet: forced release after LT idle cycles
    do_reset();
    push(1, 1'b0, 8'h51); push(2, 1'b1, 8'h61);
    exp_push(1, 8'h51);   exp_push(2, 8'h61);
    step();
    chk("t4_grant", 32'(grant), 32'b0010);
    cnt = 0;
    while (cnt < 40 && timeout !== 1'b1) begin
      step();
      cnt++;
    end
    chk("t4_timeout_cycles", cnt, 17);
    chk("t4_grant_after", 32'(grant), 0);
    step();
    chk("t4_pulse_width", 32'(timeout), 0);
    chk("t4_next_grant", 32'(grant), 32'b0100);
    drain(10);

    // Last byte arriving on the timeout edge wins over the timeout
    do_reset();
    push(1, 1'b0, 8'h71);
    exp_push(1, 8'h71); exp_push(1, 8'h72);
    step();
    repeat (16) step();
    chk("t4b_still_held", 32'(grant), 32'b0010);
    push(1, 1'b1, 8'h72);
    step();
    chk("t4b_no_timeout", 32'(timeout), 0);
    chk("t4b_released", 32'({grant, busy}), 0);
    chk("t4b_sb_empty", sb.size(), 0);
`else
    // Granted requester drops valid before acceptance: release after one cycle
    do_reset();
    tx_ready = 1'b0;
    push(1, 1'b0, 8'h51);
    step();
    chk("t4_grant", 32'(grant), 32'b0010);
    src_en[1] = 1'b0;
    tx_ready  = 1'b1;
    step();
    chk("t4_released", 32'({grant, busy, timeout}), 0);
    src_en[1] = 1'b1;
    exp_push(1, 8'h51);
    drain(10);
`endif

    // Asynchronous reset mid-packet
    do_reset();
    tx_ready = 1'b0;
    push(2, 1'b0, 8'h90); push(2, 1'b0, 8'h91); push(2, 1'b1, 8'h92);
    step();
    chk("t5_grant", 32'(grant), 32'b0100);
    chk("t5_ready_gated", 32'(req_ready), 0);
    chk("t5_tx_valid", 32'(tx_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", 32'({grant, busy, tx_valid, req_ready}), 0);
    do_reset();
    push(3, 1'b1, 8'h83); push(0, 1'b1, 8'h80);
    exp_push(0, 8'h80);   exp_push(3, 8'h83);
    step();
    chk("t5_priority", 32'(grant), 32'b0001);
    drain(20);

    // Two requesters with 3-byte packets
    do_reset();
    for (int b = 0; b < 3; b++) begin
      push(0, b == 2, 8'(8'hD0 + b));
      push(1, b == 2, 8'(8'hE0 + b));
    end
`ifdef UART_ARB_PACKET_LOCK_EN
    for (int b = 0; b < 3; b++) exp_push(0, 8'(8'hD0 + b));
    for (int b = 0; b < 3; b++) exp_push(1, 8'(8'hE0 + b));
`else
    for (int b = 0; b < 3; b++) begin
      exp_push(0, 8'(8'hD0 + b));
      exp_push(1, 8'(8'hE0 + b));
    end
`endif
    drain(40);
`ifndef UART_ARB_PACKET_LOCK_EN
    chk("t6_timeout_stuck", 32'(to_seen), 0);
`endif

    step();
    chk("end_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single transmit side of the UART driver between NUM_REQ byte-stream requesters. It sits between on-chip clients (debug console, telemetry, command responder) and the driver's tx_data/tx_valid/tx_ready port. With packet lock compiled in, it holds the grant until the requester marks its last byte. A timeout keeps a stalled requester from blocking the link.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_BITS, 8: byte width; must match the UART driver.
- LOCK_TIMEOUT, 1_000_000: idle cycles allowed inside a locked packet before a forced release; must be at least 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_data  in  NUM_REQ*DATA_BITS  requester i byte in bits [i*DATA_BITS +: DATA_BITS].
- req_valid  in  NUM_REQ  requester i has a byte.
- req_last  in  NUM_REQ  requester i byte ends its packet.
- req_ready  out  NUM_REQ  byte from requester i is accepted this cycle.
- tx_data  out  DATA_BITS  to UART driver.
- tx_valid  out  1  to UART driver.
- tx_ready  in  1  from UART driver; high while the driver is idle.
- grant  out  NUM_REQ  one-hot current owner; zero when idle.
- busy  out  1  a grant is held.
- timeout  out  1  one-cycle pulse on a forced release.

## Operation
- Transfer on requester g means grant[g] & req_valid[g] & tx_ready at a rising clk edge.
- State S_IDLE:
  - grant=0, tx_valid=0, req_ready=0.
  - If any req_valid is set, pick the first set bit searching from ptr+1 upward, modulo NUM_REQ.
  - Register grant, then move to S_SEND.
- State S_SEND:
  - tx_data = req_data slice g and tx_valid = req_valid[g], both combinational from the registered grant.
  - req_ready[g] = tx_ready; every other req_ready bit is 0.
  - On a transfer with req_last[g]=1: ptr<=g, grant<=0, move to S_IDLE.
  - On a transfer with req_last[g]=0: stay in S_SEND, clear the idle counter.
  - No transfer: the idle counter increments. At LOCK_TIMEOUT-1 the block releases: ptr<=g, grant<=0, move to S_IDLE, timeout=1 for one cycle.
- Idle counter:
  - Width $clog2(LOCK_TIMEOUT+1).
  - Clears on entry to S_SEND and on every transfer. Saturation is not reachable.
- A requester may drop req_valid before its byte is accepted. The arbiter passes this straight through and the idle counter keeps running.
- busy = (state == S_SEND).

## Timing
- Reset values:
  - state=S_IDLE, ptr=NUM_REQ-1, so requester 0 wins first.
  - grant=0, busy=0, timeout=0, tx_valid=0, req_ready=0, tx_data=0, idle counter=0.
- Arbitration latency: 1 cycle from req_valid in S_IDLE to grant/tx_valid.
- Release to next grant: 1 cycle in S_IDLE. Back-to-back packets cost 1 dead cycle, which is hidden by the driver's multi-cycle frame.
- Simultaneous requests: only one grant per arbitration. The losing requester is served no later than after NUM_REQ-1 other packets.
- Last byte and timeout on the same edge: the transfer wins. Normal release, no timeout pulse.
- A reset mid-packet drops the grant immediately. A byte already captured by the UART driver finishes under the driver's own reset domain.

## Configuration
- UART_ARB_PACKET_LOCK_EN defined:
  - The grant is held across bytes until req_last, with timeout protection as above.
- UART_ARB_PACKET_LOCK_EN undefined:
  - req_last is ignored and every transfer releases the grant, giving per-byte round-robin.
  - The idle counter and LOCK_TIMEOUT logic are removed and timeout is tied to 0.
  - A granted requester that drops req_valid is still bounded: release happens after 1 cycle without a transfer.

## Test plan
- Single requester: reset, req_valid[2]=1, data 0x41 then 0x42 with last=1. Expect grant=0b0100 one cycle later, both bytes on tx_data in order, then grant=0.
- Simultaneous packets: all four requesters request 2-byte packets at once after reset. Expect service order 0,1,2,3 and no interleaving within a packet (lock enabled).
- Fairness: requester 0 re-requests immediately after each packet, and requester 3 is also pending. Expect requester 3 granted before requester 0's second packet.
- Timeout: LOCK_TIMEOUT=16; requester 1 sends one byte with last=0, then drops valid. Expect a timeout pulse 16 idle cycles later, grant=0, and requester 2 granted next.
- Async reset: assert rst_n low mid-packet. Expect grant, busy, tx_valid and req_ready low immediately; after release, requester 0 has top priority.
- Lock disabled build: two requesters with 3-byte packets. Expect byte interleave 0,1,0,1,0,1 and timeout stuck at 0.
